// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage data cache: FSM states, byte/line types and a word-to-line helper.
package mips_mem_pkg;

  localparam int LINE_BYTES = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:LINE_BYTES-1] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } dcache_state_t;

  // Memory words carry byte k at [8k+7:8k]; line element [k] is the byte at offset k.
  function automatic line_t word_to_line(input logic [31:0] w);
    line_t l;
    for (int k = 0; k < LINE_BYTES; k++) begin
      l[k] = w[8*k +: 8];
    end
    return l;
  endfunction

endpackage

// File: rtl/mem_stage_dcache_if.sv
// Main-memory req/ack bus between the data cache (master) and the memory controller (slave).
interface mem_stage_dcache_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_rd_req, mem_wr_req, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd_req, mem_wr_req, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped valid/tag/data storage: one async read port, one byte-enabled write port.
// Only the valid bits are reset; tag and data contents are don't-care until a fill validates them.
module dcache_line_array
  import mips_mem_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int TAG_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output line_t                        rd_line,
  input  logic                         wr_en,
  input  logic                         wr_fill,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
  input  logic [LINE_BYTES-1:0]        wr_be,
  input  logic [TAG_W-1:0]             wr_tag,
  input  line_t                        wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  line_t                data_mem [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_mem[wr_idx] <= wr_tag;
      end
      for (int k = 0; k < LINE_BYTES; k++) begin
        if (wr_be[k]) begin
          data_mem[wr_idx][k] <= wr_line[k];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage direct-mapped write-through / no-write-allocate data cache with freeze-based stalling.
// Optional DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module mem_stage_dcache
  import mips_mem_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              is_LB_SB,
  input  logic [31:0]       store_data,
  output line_t             cache_data_out,
  output logic [1:0]        mem_block,
  output logic              freeze,
  mem_stage_dcache_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  dcache_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx, wr_idx;
  logic [TAG_W-1:0] tag, wr_tag, rd_tag;
  logic             rd_valid, hit, rd_hit;
  line_t            rd_line, wr_line;
  logic             arr_wr_en, wr_fill;
  logic [3:0]       wr_be, st_be;
  logic [31:0]      st_word;
  logic             start_fill, start_write;

  assign idx       = alu_result[IDX_W+1:2];
  assign tag       = alu_result[ADDR_W-1:IDX_W+2];
  assign hit       = rd_valid && (rd_tag == tag);
  assign rd_hit    = (state_q == IDLE) && mem_read && !mem_write && hit;
  assign mem_block = alu_result[1:0];
  assign st_be     = is_LB_SB ? (4'b0001 << alu_result[1:0]) : 4'b1111;
  assign st_word   = is_LB_SB ? {4{store_data[7:0]}} : store_data;

  assign cache_data_out = rd_hit ? rd_line : '0;

  // Fills are indexed by the latched request address, not the (frozen) live one.
  assign wr_idx = (state_q == FILL) ? mem.mem_addr[IDX_W+1:2] : idx;
  assign wr_tag = mem.mem_addr[ADDR_W-1:IDX_W+2];

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (arr_wr_en),
    .wr_fill  (wr_fill),
    .wr_idx   (wr_idx),
    .wr_be    (wr_be),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    freeze      = 1'b0;
    arr_wr_en   = 1'b0;
    wr_fill     = 1'b0;
    wr_be       = st_be;
    wr_line     = word_to_line(st_word);
    start_fill  = 1'b0;
    start_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d     = WRITE;
          start_write = 1'b1;
          freeze      = 1'b1;
          arr_wr_en   = hit;
        end else if (mem_read && !hit) begin
          state_d    = FILL;
          start_fill = 1'b1;
          freeze     = 1'b1;
        end
      end
      FILL: begin
        // Held through the ack cycle; the retry cycle then hits with freeze low.
        freeze = 1'b1;
        if (mem.mem_ack) begin
          state_d   = IDLE;
          arr_wr_en = 1'b1;
          wr_fill   = 1'b1;
          wr_be     = 4'b1111;
          wr_line   = word_to_line(mem.mem_rdata);
        end
      end
      WRITE: begin
        // Release on the ack cycle so the store leaves MEM on the same edge we return to IDLE.
        freeze = !mem.mem_ack;
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem.mem_addr   <= '0;
      mem.mem_rd_req <= 1'b0;
      mem.mem_wr_req <= 1'b0;
      mem.mem_wdata  <= '0;
      mem.mem_wstrb  <= '0;
    end else begin
      if (start_fill || start_write) begin
        mem.mem_addr <= {alu_result[ADDR_W-1:2], 2'b00};
      end
      if (start_fill) mem.mem_rd_req <= 1'b1;
      if (start_write) begin
        mem.mem_wr_req <= 1'b1;
        mem.mem_wdata  <= st_word;
        mem.mem_wstrb  <= st_be;
      end
      if (state_q == FILL && mem.mem_ack) mem.mem_rd_req <= 1'b0;
      if (state_q == WRITE && mem.mem_ack) begin
        mem.mem_wr_req <= 1'b0;
        mem.mem_wstrb  <= '0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (start_fill && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed self-checking bench for mem_stage_dcache: fills, hits, stores, conflict eviction, reset abort.
module tb_mem_stage_dcache;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] alu_result;
  logic        mem_read, mem_write, is_LB_SB;
  logic [31:0] store_data;
  line_t       cache_data_out;
  logic [1:0]  mem_block;
  logic        freeze;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  mem_stage_dcache_if #(.ADDR_W(32)) bus ();

  mem_stage_dcache #(.NUM_LINES(64), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .alu_result     (alu_result),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .is_LB_SB       (is_LB_SB),
    .store_data     (store_data),
    .cache_data_out (cache_data_out),
    .mem_block      (mem_block),
    .freeze         (freeze),
    .mem            (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_word(input line_t l);
    logic [31:0] w;
    for (int k = 0; k < LINE_BYTES; k++) w[8*k +: 8] = l[k];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle ack pulse; inputs change #1 after the edge.
  task automatic ack_cycle(input logic [31:0] rdata);
    bus.mem_rdata = rdata;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    alu_result = '0; mem_read = 0; mem_write = 0; is_LB_SB = 0; store_data = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    #22;
    check("rst_freeze", freeze, 0);
    check("rst_rd_req", bus.mem_rd_req, 0);
    check("rst_wr_req", bus.mem_wr_req, 0);
    check("rst_wstrb", bus.mem_wstrb, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    rst_b = 1'b1;
    tick();

    // Cold load misses and fills.
    alu_result = 32'h100; mem_read = 1;
    #1;
    check("miss_freeze_lookup", freeze, 1);
    check("miss_data_zero", line_word(cache_data_out), 0);
    tick();
    check("fill_rd_req", bus.mem_rd_req, 1);
    check("fill_addr", bus.mem_addr, 32'h100);
    check("fill_freeze", freeze, 1);
    ack_cycle(32'hDDCCBBAA);
    check("retry_freeze", freeze, 0);
    check("retry_rd_req", bus.mem_rd_req, 0);
    check("retry_data", line_word(cache_data_out), 32'hDDCCBBAA);

    // Hit at offset 2, same cycle.
    alu_result = 32'h102;
    #1;
    check("hit_freeze", freeze, 0);
    check("hit_block", mem_block, 2);
    check("hit_data", line_word(cache_data_out), 32'hDDCCBBAA);
    check("hit_no_req", bus.mem_rd_req | bus.mem_wr_req, 0);
    tick();
`ifdef DCACHE_STATS_EN
    check("stats_hits", hit_count, 1);
    check("stats_misses", miss_count, 1);
`endif

    // SB hit: write-through, line patched.
    mem_read = 0; mem_write = 1; is_LB_SB = 1; store_data = 32'h0000005A; alu_result = 32'h101;
    #1;
    check("sb_freeze_lookup", freeze, 1);
    check("sb_data_zero", line_word(cache_data_out), 0);
    tick();
    check("sb_wr_req", bus.mem_wr_req, 1);
    check("sb_wstrb", bus.mem_wstrb, 4'b0010);
    check("sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
    check("sb_addr", bus.mem_addr, 32'h100);
    bus.mem_ack = 1'b1;
    #1;
    check("sb_freeze_done", freeze, 0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("sb_wr_req_drop", bus.mem_wr_req, 0);
    mem_write = 0; is_LB_SB = 0; mem_read = 1; alu_result = 32'h100;
    #1;
    check("sb_reload_freeze", freeze, 0);
    check("sb_reload_data", line_word(cache_data_out), 32'hDDCC5AAA);
    tick();

    // SW miss to 0x200 (same index): no allocate.
    mem_read = 0; mem_write = 1; store_data = 32'h11223344; alu_result = 32'h200;
    tick();
    check("sw_wstrb", bus.mem_wstrb, 4'b1111);
    check("sw_wdata", bus.mem_wdata, 32'h11223344);
    tick();
    check("sw_hold_freeze", freeze, 1);
    check("sw_hold_req", bus.mem_wr_req, 1);
    check("sw_hold_addr", bus.mem_addr, 32'h200);
    ack_cycle(32'h0);
    mem_write = 0; mem_read = 1; alu_result = 32'h100;
    #1;
    check("sw_line_untouched", line_word(cache_data_out), 32'hDDCC5AAA);
    check("sw_line_hit", freeze, 0);
    tick();

    // Load 0x200 misses, evicting 0x100.
    alu_result = 32'h200;
    #1;
    check("noalloc_miss", freeze, 1);
    tick();
    check("evict_addr", bus.mem_addr, 32'h200);
    ack_cycle(32'h11223344);
    check("evict_data", line_word(cache_data_out), 32'h11223344);
    alu_result = 32'h100;
    #1;
    check("evicted_miss", freeze, 1);
    tick();
    check("evicted_rd_req", bus.mem_rd_req, 1);

    // Reset in FILL aborts; a stray ack afterwards is ignored.
    mem_read = 0;
    rst_b = 1'b0;
    #1;
    check("abort_freeze", freeze, 0);
    check("abort_rd_req", bus.mem_rd_req, 0);
    check("abort_addr", bus.mem_addr, 0);
    rst_b = 1'b1;
    tick();
    ack_cycle(32'hFFFFFFFF);
    check("stray_rd_req", bus.mem_rd_req, 0);
    check("stray_freeze", freeze, 0);
    mem_read = 1;
    #1;
    check("stray_no_fill", freeze, 1);
    check("stray_data_zero", line_word(cache_data_out), 0);
    mem_read = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
